// File: rtl/pc_trace_monitor_if.sv
// Control, capture and drain signals between a PC trace monitor and whoever
// drives the CPU program counter and empties the trace.
interface pc_trace_monitor_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          en;
  logic          clr;
  logic [31:0]   pc;
  logic          rd_en;
  logic [32:0]   rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          halted;
  logic [31:0]   cycle_cnt;

  modport master (
    output en, clr, pc, rd_en,
    input  rd_data, rd_valid, count, empty, full, overflow, halted, cycle_cnt
  );

  modport slave (
    input  en, clr, pc, rd_en,
    output rd_data, rd_valid, count, empty, full, overflow, halted, cycle_cnt
  );
endinterface

// File: rtl/pc_trace_monitor.sv
// Watches a CPU program counter, logs every PC change with a jump flag into a
// trace FIFO, and declares halt once the PC stays put for HALT_CYCLES samples.
module pc_trace_monitor #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_CYCLES = 8,
  parameter int unsigned PC_STEP     = 4
) (
  input  logic               clk,
  input  logic               rst,
  pc_trace_monitor_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(HALT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_HALTED
  } state_t;

  state_t        state;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   last_pc;
  logic          first;
  logic [SW-1:0] same_cnt;
  logic [32:0]   rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          halted;
  logic [31:0]   cycle_cnt;

  logic          sample;
  logic          changed;
  logic          wr_req;
  logic          jump;
  logic          halt_hit;
  logic          rd_fire;
  logic          wr_fire;
  logic          drop;
  logic [SW-1:0] same_inc;
  logic [CW-1:0] count_nxt;

  // Per-cycle capture/pop decisions; COUNT alone decides full and empty.
  always_comb begin
    sample    = (state == S_CAPTURE) && bus.en && !bus.clr;
    changed   = (bus.pc != last_pc);
    wr_req    = sample && (first || changed);
    jump      = !first && (bus.pc != (last_pc + 32'(PC_STEP)));
    same_inc  = same_cnt + SW'(1);
    halt_hit  = sample && !first && !changed && (same_inc == SW'(HALT_CYCLES - 1));
    rd_fire   = bus.rd_en && (count != CW'(0)) && !bus.clr;
    wr_fire   = wr_req && ((count != CW'(DEPTH)) || rd_fire);
    drop      = wr_req && !wr_fire;
    count_nxt = count + CW'(wr_fire) - CW'(rd_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_pc   <= '0;
      first     <= 1'b1;
      same_cnt  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:    if (bus.en) state <= S_CAPTURE;
        S_CAPTURE: begin
          if (!bus.en)       state <= S_IDLE;
          else if (halt_hit) state <= S_HALTED;
        end
        S_HALTED:  state <= S_HALTED;
        default:   state <= S_IDLE;
      endcase

      if (sample) begin
        if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
        if (first || changed) begin
          last_pc  <= bus.pc;
          first    <= 1'b0;
          same_cnt <= '0;
        end else begin
          same_cnt <= same_inc;
        end
      end

      if (halt_hit) halted <= 1'b1;
      if (drop)     overflow <= 1'b1;

      if (wr_fire) begin
        mem[wr_ptr] <= {jump, bus.pc};
        wr_ptr      <= wr_ptr + AW'(1);
      end

      // Popped data stays on rd_data; rd_valid marks only the pop cycle.
      if (rd_fire) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      rd_valid <= rd_fire;

      count <= count_nxt;
      empty <= (count_nxt == CW'(0));
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.count     = count;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow;
  assign bus.halted    = halted;
  assign bus.cycle_cnt = cycle_cnt;
endmodule

// File: tb/tb_pc_trace_monitor.sv
// Scenario bench for pc_trace_monitor: expected trace entries are queued as
// PCs are driven and compared as they are drained.
module tb_pc_trace_monitor;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned HALT_CYCLES = 8;
  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned CW          = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  pc_trace_monitor_if #(.DEPTH(DEPTH)) bus ();

  pc_trace_monitor #(
    .DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES), .PC_STEP(PC_STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.en = 1'b0; bus.clr = 1'b0; bus.rd_en = 1'b0; bus.pc = '0;
    #150;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  // IDLE -> CAPTURE takes one edge before the first sample.
  task automatic start_capture();
    bus.en = 1'b1;
    tick();
  endtask

  task automatic drive_pc(input logic [31:0] pc);
    bus.pc = pc;
    tick();
  endtask

  task automatic expect_entry(input logic jump, input logic [31:0] pc);
    exp_q.push_back({jump, pc});
  endtask

  task automatic drain(input int n);
    logic [32:0] e;
    bus.rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL drain_extra: rd_valid=%b rd_data=%h, no entry expected", bus.rd_valid, bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
          n_err++;
          $display("FAIL drain[%0d]: rd_valid=%b rd_data=%h, required 1 %h", i, bus.rd_valid, bus.rd_data, e);
        end
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (bus.rd_data !== 33'd0 || bus.rd_valid !== 1'b0 || bus.count !== CW'(0) || bus.empty !== 1'b1 ||
        bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.halted !== 1'b0 || bus.cycle_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: data=%h v=%b cnt=%0d e=%b f=%b ov=%b h=%b cyc=%0d", bus.rd_data, bus.rd_valid,
               bus.count, bus.empty, bus.full, bus.overflow, bus.halted, bus.cycle_cnt);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    start_capture();
    for (int i = 0; i < 4; i++) begin
      drive_pc(32'(4 * i));
      expect_entry(1'b0, 32'(4 * i));
    end
    n_vec++;
    if (bus.count !== CW'(4) || bus.empty !== 1'b0 || bus.cycle_cnt !== 32'd4) begin
      n_err++;
      $display("FAIL seq_status: count=%0d empty=%b cyc=%0d, required 4 0 4", bus.count, bus.empty, bus.cycle_cnt);
    end
    bus.en = 1'b0;
    drain(4);
    n_vec++;
    if (bus.empty !== 1'b1 || bus.count !== CW'(0)) begin
      n_err++;
      $display("FAIL seq_empty: empty=%b count=%0d, required 1 0", bus.empty, bus.count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    start_capture();
    drive_pc(32'h8);  expect_entry(1'b0, 32'h8);
    drive_pc(32'h40); expect_entry(1'b1, 32'h40);
    drive_pc(32'h44); expect_entry(1'b0, 32'h44);
    // Leaving and re-entering CAPTURE keeps last_pc, so 0x48 is sequential.
    bus.en = 1'b0; bus.pc = 32'h48;
    tick();
    start_capture();
    drive_pc(32'h48); expect_entry(1'b0, 32'h48);
    n_vec++;
    if (bus.cycle_cnt !== 32'd4) begin
      n_err++;
      $display("FAIL branch_cycles: cyc=%0d, required 4", bus.cycle_cnt);
    end
    bus.en = 1'b0;
    drain(4);
  endtask

  task automatic test_halt();
    do_reset();
    start_capture();
    drive_pc(32'h1C); expect_entry(1'b0, 32'h1C);
    for (int i = 0; i < 8; i++) begin
      drive_pc(32'h20);
      if (i == 0) expect_entry(1'b0, 32'h20);
      n_vec++;
      if (bus.halted !== (i == 7)) begin
        n_err++;
        $display("FAIL halt_sample[%0d]: halted=%b, required %b", i, bus.halted, (i == 7));
      end
    end
    drive_pc(32'h24);
    drive_pc(32'h100);
    n_vec++;
    if (bus.halted !== 1'b1 || bus.count !== CW'(2) || bus.cycle_cnt !== 32'd9) begin
      n_err++;
      $display("FAIL halt_hold: halted=%b count=%0d cyc=%0d, required 1 2 9", bus.halted, bus.count, bus.cycle_cnt);
    end
    drain(2);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    n_vec++;
    if (bus.halted !== 1'b0 || bus.cycle_cnt !== 32'd0 || bus.count !== CW'(0) || bus.empty !== 1'b1) begin
      n_err++;
      $display("FAIL clr_halted: halted=%b cyc=%0d count=%0d empty=%b, required 0 0 0 1", bus.halted,
               bus.cycle_cnt, bus.count, bus.empty);
    end
    tick();
    n_vec++;
    if (bus.cycle_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL clr_to_idle: cyc=%0d, required 0", bus.cycle_cnt);
    end
    drive_pc(32'h100); expect_entry(1'b0, 32'h100);
    n_vec++;
    if (bus.cycle_cnt !== 32'd1 || bus.count !== CW'(1)) begin
      n_err++;
      $display("FAIL clr_restart: cyc=%0d count=%0d, required 1 1", bus.cycle_cnt, bus.count);
    end
    bus.en = 1'b0;
    drain(1);
  endtask

  task automatic test_overflow();
    do_reset();
    start_capture();
    for (int i = 0; i < 17; i++) begin
      drive_pc(32'h1000 + 32'(4 * i));
      if (i < 16) expect_entry(1'b0, 32'h1000 + 32'(4 * i));
      if (i == 15) begin
        n_vec++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_at_16: full=%b overflow=%b, required 1 0", bus.full, bus.overflow);
        end
      end
    end
    n_vec++;
    if (bus.full !== 1'b1 || bus.count !== CW'(16) || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_at_17: full=%b count=%0d overflow=%b, required 1 16 1", bus.full, bus.count, bus.overflow);
    end
    bus.en = 1'b0;
    drain(16);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_vec++;
    if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drained: empty=%b rd_valid=%b overflow=%b, required 1 0 1", bus.empty, bus.rd_valid,
               bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    do_reset();
    start_capture();
    for (int i = 0; i < 16; i++) begin
      drive_pc(32'h2000 + 32'(4 * i));
      expect_entry(1'b0, 32'h2000 + 32'(4 * i));
    end
    bus.pc = 32'h3000;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    e = exp_q.pop_front();
    expect_entry(1'b1, 32'h3000);
    n_vec++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      n_err++;
      $display("FAIL b2b_pop: rd_valid=%b rd_data=%h, required 1 %h", bus.rd_valid, bus.rd_data, e);
    end
    n_vec++;
    if (bus.count !== CW'(16) || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_status: count=%0d full=%b overflow=%b, required 16 1 0", bus.count, bus.full, bus.overflow);
    end
    bus.en = 1'b0;
    drain(16);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_vec++;
    if (bus.rd_valid !== 1'b0 || bus.count !== CW'(0) || bus.empty !== 1'b1) begin
      n_err++;
      $display("FAIL empty_read: rd_valid=%b count=%0d empty=%b, required 0 0 1", bus.rd_valid, bus.count, bus.empty);
    end
  endtask

  task automatic test_reset_mid_capture();
    logic [32:0] e;
    do_reset();
    start_capture();
    for (int i = 0; i < 5; i++) begin
      drive_pc(32'h500 + 32'(4 * i));
      expect_entry(1'b0, 32'h500 + 32'(4 * i));
    end
    bus.pc = 32'h514;
    bus.rd_en = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_vec++;
    if (bus.rd_data !== e || bus.count !== CW'(5)) begin
      n_err++;
      $display("FAIL mid_pop: rd_data=%h count=%0d, required %h 5", bus.rd_data, bus.count, e);
    end
    rst = 1'b0;
    bus.pc = 32'h600;
    tick();
    n_vec++;
    if (bus.rd_data !== 33'd0 || bus.rd_valid !== 1'b0 || bus.count !== CW'(0) || bus.empty !== 1'b1 ||
        bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.halted !== 1'b0 || bus.cycle_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset: data=%h v=%b cnt=%0d e=%b f=%b ov=%b h=%b cyc=%0d", bus.rd_data, bus.rd_valid,
               bus.count, bus.empty, bus.full, bus.overflow, bus.halted, bus.cycle_cnt);
    end
    exp_q.delete();
    bus.rd_en = 1'b0;
    rst = 1'b1;
    start_capture();
    drive_pc(32'h40); expect_entry(1'b0, 32'h40);
    bus.en = 1'b0;
    drain(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_overflow();
    test_back_to_back();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
